// File: rtl/bundle_issue_ctrl_pkg.sv
// Shared CPU width parameters used by fetch, the bundle issue queue and decode.
package bundle_issue_ctrl_pkg;
    localparam int ADDR_W     = 64;
    localparam int INSTR_W    = 32;
    localparam int BUNDLE_W   = 4 * INSTR_W;
    localparam int PID_W      = 32;
    localparam int TID_W      = 64;
    localparam int MAJ_W      = 64;
    localparam int FIFO_DEPTH = 4;
    localparam int LEN_W      = 2;

    typedef logic [LEN_W-1:0] bundle_len_t;
endpackage

// File: rtl/bundle_issue_ctrl_if.sv
// Fetch/decode-facing signal group of the bundle issue controller.
interface bundle_issue_ctrl_if #(
    parameter int addressWidth            = bundle_issue_ctrl_pkg::ADDR_W,
    parameter int instructionWidth        = bundle_issue_ctrl_pkg::INSTR_W,
    parameter int bundleSize              = 4 * instructionWidth,
    parameter int PidSize                 = bundle_issue_ctrl_pkg::PID_W,
    parameter int TidSize                 = bundle_issue_ctrl_pkg::TID_W,
    parameter int instructionCounterWidth = bundle_issue_ctrl_pkg::MAJ_W,
    parameter int fifoDepth               = bundle_issue_ctrl_pkg::FIFO_DEPTH
);
    logic                                 flush_i;
    logic [instructionCounterWidth-1:0]   flushMajId_i;
    logic                                 fetchValid_i;
    logic                                 fetchReady_o;
    logic [bundleSize-1:0]                bundle_i;
    logic [addressWidth-1:0]              bundleAddress_i;
    logic [1:0]                           bundleLen_i;
    logic [PidSize-1:0]                   bundlePid_i;
    logic [TidSize-1:0]                   bundleTid_i;
    logic                                 decodeStall_i;
    logic                                 enable_o;
    logic [bundleSize-1:0]                bundle_o;
    logic [addressWidth-1:0]              bundleAddress_o;
    logic [1:0]                           bundleLen_o;
    logic [PidSize-1:0]                   bundlePid_o;
    logic [TidSize-1:0]                   bundleTid_o;
    logic [instructionCounterWidth-1:0]   bundleStartMajId_o;
    logic [$clog2(fifoDepth):0]           occupancy_o;

    modport master (
        output flush_i, flushMajId_i, fetchValid_i, bundle_i, bundleAddress_i,
               bundleLen_i, bundlePid_i, bundleTid_i, decodeStall_i,
        input  fetchReady_o, enable_o, bundle_o, bundleAddress_o, bundleLen_o,
               bundlePid_o, bundleTid_o, bundleStartMajId_o, occupancy_o
    );

    modport slave (
        input  flush_i, flushMajId_i, fetchValid_i, bundle_i, bundleAddress_i,
               bundleLen_i, bundlePid_i, bundleTid_i, decodeStall_i,
        output fetchReady_o, enable_o, bundle_o, bundleAddress_o, bundleLen_o,
               bundlePid_o, bundleTid_o, bundleStartMajId_o, occupancy_o
    );
endinterface

// File: rtl/bundle_fifo.sv
// Bundle queue storage with wrapping head/tail pointers and occupancy count.
module bundle_fifo #(
    parameter int dataWidth = 8,
    parameter int depth     = 4
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [dataWidth-1:0]   wr_data,
    output logic [dataWidth-1:0]   rd_data,
    output logic [$clog2(depth):0] occupancy
);
    localparam int PTR_W = $clog2(depth);
    localparam int OCC_W = PTR_W + 1;

    logic [dataWidth-1:0] mem [depth];
    logic [PTR_W-1:0]     head;
    logic [PTR_W-1:0]     tail;

    // Pointers wrap naturally because depth is a power of two.
    always_ff @(posedge clock_i) begin
        if (!reset_i || flush) begin
            head      <= '0;
            tail      <= '0;
            occupancy <= '0;
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            case ({push, pop})
                2'b10:   occupancy <= occupancy + OCC_W'(1);
                2'b01:   occupancy <= occupancy - OCC_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    always_ff @(posedge clock_i) begin
        if (push) mem[tail] <= wr_data;
    end

    assign rd_data = mem[head];
endmodule

// File: rtl/bundle_issue_ctrl.sv
// Queues fetched bundles and issues them to the bundle parser, tagging each
// issue with the major ID of its first instruction.
module bundle_issue_ctrl
    import bundle_issue_ctrl_pkg::*;
#(
    parameter int addressWidth            = ADDR_W,
    parameter int instructionWidth        = INSTR_W,
    parameter int bundleSize              = 4 * instructionWidth,
    parameter int PidSize                 = PID_W,
    parameter int TidSize                 = TID_W,
    parameter int instructionCounterWidth = MAJ_W,
    parameter int fifoDepth               = FIFO_DEPTH
) (
    input logic                clock_i,
    input logic                reset_i,
    bundle_issue_ctrl_if.slave bus
);
    localparam int OCC_W   = $clog2(fifoDepth) + 1;
    localparam int ENTRY_W = bundleSize + addressWidth + LEN_W + PidSize + TidSize;

    typedef logic [instructionCounterWidth-1:0] maj_t;

    logic [OCC_W-1:0]        occupancy;
    logic [ENTRY_W-1:0]      head;
    logic                    ready;
    logic                    push;
    logic                    pop;
    logic [bundleSize-1:0]   head_bundle;
    logic [addressWidth-1:0] head_address;
    bundle_len_t             head_len;
    logic [PidSize-1:0]      head_pid;
    logic [TidSize-1:0]      head_tid;

    logic                    enable;
    logic [bundleSize-1:0]   issue_bundle;
    logic [addressWidth-1:0] issue_address;
    bundle_len_t             issue_len;
    logic [PidSize-1:0]      issue_pid;
    logic [TidSize-1:0]      issue_tid;
    maj_t                    issue_start_maj;
    maj_t                    next_maj;

    // Ready is judged on the pre-pop occupancy, so a full queue refuses a push
    // even on an edge where it also pops.
    assign ready = reset_i && !bus.flush_i && (occupancy < OCC_W'(fifoDepth));
    assign push  = bus.fetchValid_i && ready;
    assign pop   = reset_i && !bus.flush_i && !bus.decodeStall_i && (occupancy != '0);

    assign {head_bundle, head_address, head_len, head_pid, head_tid} = head;

    bundle_fifo #(
        .dataWidth(ENTRY_W),
        .depth    (fifoDepth)
    ) u_fifo (
        .clock_i  (clock_i),
        .reset_i  (reset_i),
        .flush    (bus.flush_i),
        .push     (push),
        .pop      (pop),
        .wr_data  ({bus.bundle_i, bus.bundleAddress_i, bus.bundleLen_i,
                    bus.bundlePid_i, bus.bundleTid_i}),
        .rd_data  (head),
        .occupancy(occupancy)
    );

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            enable          <= 1'b0;
            issue_bundle    <= '0;
            issue_address   <= '0;
            issue_len       <= '0;
            issue_pid       <= '0;
            issue_tid       <= '0;
            issue_start_maj <= '0;
            next_maj        <= '0;
        end else if (bus.flush_i) begin
            enable   <= 1'b0;
            next_maj <= bus.flushMajId_i;
        end else if (pop) begin
            enable          <= 1'b1;
            issue_bundle    <= head_bundle;
            issue_address   <= head_address;
            issue_len       <= head_len;
            issue_pid       <= head_pid;
            issue_tid       <= head_tid;
            issue_start_maj <= next_maj;
            next_maj        <= next_maj + maj_t'(head_len) + maj_t'(1);
        end else begin
            enable <= 1'b0;
        end
    end

    assign bus.fetchReady_o       = ready;
    assign bus.occupancy_o        = occupancy;
    assign bus.enable_o           = enable;
    assign bus.bundle_o           = issue_bundle;
    assign bus.bundleAddress_o    = issue_address;
    assign bus.bundleLen_o        = issue_len;
    assign bus.bundlePid_o        = issue_pid;
    assign bus.bundleTid_o        = issue_tid;
    assign bus.bundleStartMajId_o = issue_start_maj;
endmodule
